// File: rtl/framebuffer_pixel_merger.sv
// framebuffer_pixel_merger
//   Collects single-pixel writes from the fragment pipeline into one memory-beat
//   accumulator. Writes that land on the accumulated beat are merged in place.
//   A write to a different beat evicts the accumulator, and so does a flush
//   (tlast). Either way the beat goes out as a full-width beat with byte strobes.
//
// Ports
//   aclk, resetn                 clock (rising edge), async active-low reset
//   s_pixel_t{valid,ready}       pixel write handshake
//   s_pixel_taddr                pixel index (beat = taddr>>SLOT_W, slot = low bits)
//   s_pixel_tdata/tmask          pixel colour and per-byte enable
//   s_pixel_tlast                flush after merging this pixel
//   m_beat_t{valid,ready}        beat handshake (valid is registered)
//   m_beat_taddr                 byte address of the beat
//   m_beat_tdata/tstrb           beat data and byte strobes
//   m_beat_tlast                 beat closes a flush
module framebuffer_pixel_merger #(
    parameter int STRB_WIDTH  = 16,
    parameter int PIXEL_WIDTH = 16,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                      aclk,
    input  logic                      resetn,
    input  logic                      s_pixel_tvalid,
    output logic                      s_pixel_tready,
    input  logic [ADDR_WIDTH-1:0]     s_pixel_taddr,
    input  logic [PIXEL_WIDTH-1:0]    s_pixel_tdata,
    input  logic [PIXEL_WIDTH/8-1:0]  s_pixel_tmask,
    input  logic                      s_pixel_tlast,
    output logic                      m_beat_tvalid,
    input  logic                      m_beat_tready,
    output logic [ADDR_WIDTH-1:0]     m_beat_taddr,
    output logic [STRB_WIDTH*8-1:0]   m_beat_tdata,
    output logic [STRB_WIDTH-1:0]     m_beat_tstrb,
    output logic                      m_beat_tlast
);

    localparam int MASK_WIDTH   = PIXEL_WIDTH / 8;
    localparam int PIX_PER_BEAT = STRB_WIDTH / MASK_WIDTH;
    localparam int SLOT_W       = $clog2(PIX_PER_BEAT);
    localparam int BYTE_SH      = $clog2(STRB_WIDTH);
    localparam int DATA_W       = STRB_WIDTH * 8;

    typedef enum logic [1:0] {ST_EMPTY, ST_ACCUM, ST_FLUSH} state_t;

    state_t state, nxt_state;

    // Accumulator; "valid" is implied by state != ST_EMPTY.
    logic [ADDR_WIDTH-1:0] acc_beat;
    logic [DATA_W-1:0]     acc_data;
    logic [STRB_WIDTH-1:0] acc_strb;

    logic [ADDR_WIDTH-1:0] in_beat;
    logic [SLOT_W-1:0]     in_slot;
    logic [STRB_WIDTH-1:0] pix_strb;
    logic [DATA_W-1:0]     pix_data;
    logic [DATA_W-1:0]     new_data;
    logic [DATA_W-1:0]     mrg_data;
    logic                  hit, out_free, rdy;
    logic                  acc_alloc, acc_merge, acc_clear, out_load, out_last;

    assign in_beat  = s_pixel_taddr >> SLOT_W;
    assign in_slot  = s_pixel_taddr[SLOT_W-1:0];
    assign hit      = (in_beat == acc_beat);
    assign out_free = !m_beat_tvalid || m_beat_tready;

    // Pixel placed at its slot position inside the beat.
    assign pix_strb = {{(STRB_WIDTH-MASK_WIDTH){1'b0}}, s_pixel_tmask} << (in_slot * MASK_WIDTH);
    assign pix_data = {{(DATA_W-PIXEL_WIDTH){1'b0}}, s_pixel_tdata} << (in_slot * PIXEL_WIDTH);

    // Per byte lane: a fresh beat zeroes unwritten bytes, a merge keeps the old ones.
    for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_lane
        assign new_data[8*b +: 8] = pix_strb[b] ? pix_data[8*b +: 8] : 8'h00;
        assign mrg_data[8*b +: 8] = pix_strb[b] ? pix_data[8*b +: 8] : acc_data[8*b +: 8];
    end

    // Ready is forced low while reset is asserted even though state reads EMPTY.
    assign s_pixel_tready = rdy && resetn;

    always_comb begin
        nxt_state = state;
        rdy       = 1'b0;
        acc_alloc = 1'b0;
        acc_merge = 1'b0;
        acc_clear = 1'b0;
        out_load  = 1'b0;
        out_last  = 1'b0;
        case (state)
            ST_EMPTY: begin
                rdy = 1'b1;
                if (s_pixel_tvalid) begin
                    acc_alloc = 1'b1;
                    nxt_state = s_pixel_tlast ? ST_FLUSH : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (hit) begin
                    rdy = 1'b1;
                    if (s_pixel_tvalid) begin
                        acc_merge = 1'b1;
                        if (s_pixel_tlast) nxt_state = ST_FLUSH;
                    end
                end else begin
                    // A miss needs the output register to take the evicted beat.
                    rdy = out_free;
                    if (s_pixel_tvalid && out_free) begin
                        out_load  = 1'b1;
                        acc_alloc = 1'b1;
                        nxt_state = s_pixel_tlast ? ST_FLUSH : ST_ACCUM;
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    out_load  = 1'b1;
                    out_last  = 1'b1;
                    acc_clear = 1'b1;
                    nxt_state = ST_EMPTY;
                end
            end
            default: nxt_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) state <= ST_EMPTY;
        else         state <= nxt_state;
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            acc_beat <= '0;
            acc_data <= '0;
            acc_strb <= '0;
        end else if (acc_alloc) begin
            acc_beat <= in_beat;
            acc_data <= new_data;
            acc_strb <= pix_strb;
        end else if (acc_merge) begin
            acc_data <= mrg_data;
            acc_strb <= acc_strb | pix_strb;
        end else if (acc_clear) begin
            acc_beat <= '0;
            acc_data <= '0;
            acc_strb <= '0;
        end
    end

    // Output register samples the accumulator before any same-edge reload.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            m_beat_tvalid <= 1'b0;
            m_beat_taddr  <= '0;
            m_beat_tdata  <= '0;
            m_beat_tstrb  <= '0;
            m_beat_tlast  <= 1'b0;
        end else if (out_load) begin
            m_beat_tvalid <= 1'b1;
            m_beat_taddr  <= acc_beat << BYTE_SH;
            m_beat_tdata  <= acc_data;
            m_beat_tstrb  <= acc_strb;
            m_beat_tlast  <= out_last;
        end else if (m_beat_tready) begin
            m_beat_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_framebuffer_pixel_merger.sv
module tb_framebuffer_pixel_merger;

    logic         aclk = 1'b0;
    logic         resetn;
    logic         s_pixel_tvalid;
    logic         s_pixel_tready;
    logic [31:0]  s_pixel_taddr;
    logic [15:0]  s_pixel_tdata;
    logic [1:0]   s_pixel_tmask;
    logic         s_pixel_tlast;
    logic         m_beat_tvalid;
    logic         m_beat_tready;
    logic [31:0]  m_beat_taddr;
    logic [127:0] m_beat_tdata;
    logic [15:0]  m_beat_tstrb;
    logic         m_beat_tlast;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0]  a;
        logic [127:0] d;
        logic [15:0]  s;
        logic         l;
    } beat_t;
    beat_t q[$];

    framebuffer_pixel_merger #(.STRB_WIDTH(16), .PIXEL_WIDTH(16), .ADDR_WIDTH(32)) dut (
        .aclk           (aclk),
        .resetn         (resetn),
        .s_pixel_tvalid (s_pixel_tvalid),
        .s_pixel_tready (s_pixel_tready),
        .s_pixel_taddr  (s_pixel_taddr),
        .s_pixel_tdata  (s_pixel_tdata),
        .s_pixel_tmask  (s_pixel_tmask),
        .s_pixel_tlast  (s_pixel_tlast),
        .m_beat_tvalid  (m_beat_tvalid),
        .m_beat_tready  (m_beat_tready),
        .m_beat_taddr   (m_beat_taddr),
        .m_beat_tdata   (m_beat_tdata),
        .m_beat_tstrb   (m_beat_tstrb),
        .m_beat_tlast   (m_beat_tlast)
    );

    always #5 aclk = ~aclk;

    // Inputs change at posedge+2, so negedge sees the values the next edge will use.
    always @(negedge aclk)
        if (resetn && m_beat_tvalid && m_beat_tready)
            q.push_back('{m_beat_taddr, m_beat_tdata, m_beat_tstrb, m_beat_tlast});

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge aclk);
            #2;
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [15:0] d, input logic [1:0] m, input logic l);
        bit done = 1'b0;
        s_pixel_tvalid = 1'b1;
        s_pixel_taddr  = a;
        s_pixel_tdata  = d;
        s_pixel_tmask  = m;
        s_pixel_tlast  = l;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge aclk);
            done = s_pixel_tready;
            @(posedge aclk);
            #2;
        end
        s_pixel_tvalid = 1'b0;
        s_pixel_tlast  = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 100 && q.size() < n; i++) tick();
    endtask

    task automatic expect_beat(input string tag, input logic [31:0] a, input logic [127:0] d,
                               input logic [15:0] s, input logic l);
        beat_t b;
        if (q.size() == 0) begin
            chk({tag, "_present"}, 0, 1);
            return;
        end
        b = q.pop_front();
        chk({tag, "_addr"}, b.a, a);
        chk({tag, "_data"}, b.d, d);
        chk({tag, "_strb"}, b.s, s);
        chk({tag, "_last"}, b.l, l);
    endtask

    initial begin
        resetn = 1'b0;
        m_beat_tready = 1'b0;
        s_pixel_tvalid = 1'b0;
        s_pixel_taddr = '0;
        s_pixel_tdata = '0;
        s_pixel_tmask = '0;
        s_pixel_tlast = 1'b0;

        // Reset state
        tick(3);
        chk("rst_tready", s_pixel_tready, 0);
        chk("rst_tvalid", m_beat_tvalid, 0);
        chk("rst_tdata", m_beat_tdata, 0);
        chk("rst_tstrb", m_beat_tstrb, 0);
        chk("rst_tlast", m_beat_tlast, 0);
        resetn = 1'b1;
        tick();
        chk("post_rst_tready", s_pixel_tready, 1);

        // 1: full beat of 8 adjacent pixels, flushed by the last one
        m_beat_tready = 1'b1;
        q.delete();
        for (int i = 0; i < 8; i++) send(i, 16'(16'h1111 * i), 2'b11, i == 7);
        wait_beats(1);
        expect_beat("t1", 32'h0, 128'h7777_6666_5555_4444_3333_2222_1111_0000, 16'hFFFF, 1'b1);
        tick(3);

        // 2: miss evicts beat 0, flush emits beat 1 (slots 1 and 2 -> bytes 2..5)
        q.delete();
        send(3, 16'hABCD, 2'b11, 1'b0);
        send(9, 16'h1234, 2'b11, 1'b0);
        send(10, 16'h5678, 2'b11, 1'b1);
        wait_beats(2);
        expect_beat("t2a", 32'h0,  128'h0000_0000_0000_0000_ABCD_0000_0000_0000, 16'h00C0, 1'b0);
        expect_beat("t2b", 32'h10, 128'h0000_0000_0000_0000_0000_5678_1234_0000, 16'h003C, 1'b1);
        tick(3);

        // 3: output stalled -> miss is refused, hit still merges
        q.delete();
        m_beat_tready = 1'b0;
        send(0, 16'h0101, 2'b11, 1'b0);
        send(8, 16'h0808, 2'b11, 1'b0);
        s_pixel_tvalid = 1'b1;
        s_pixel_taddr  = 32'd16;
        s_pixel_tdata  = 16'h1616;
        s_pixel_tmask  = 2'b11;
        s_pixel_tlast  = 1'b0;
        tick(3);
        chk("t3_miss_tready", s_pixel_tready, 0);
        chk("t3_hold_valid", m_beat_tvalid, 1);
        chk("t3_hold_addr", m_beat_taddr, 0);
        chk("t3_hold_strb", m_beat_tstrb, 16'h0003);
        send(9, 16'h0909, 2'b11, 1'b1);
        tick(2);
        chk("t3_flush_tready", s_pixel_tready, 0);
        chk("t3_hold2_addr", m_beat_taddr, 0);
        m_beat_tready = 1'b1;
        wait_beats(2);
        expect_beat("t3a", 32'h0,  128'h0101, 16'h0003, 1'b0);
        expect_beat("t3b", 32'h10, 128'h0909_0808, 16'h000F, 1'b1);
        tick(3);

        // 4: same slot written twice with disjoint byte masks
        q.delete();
        send(5, 16'h00AA, 2'b01, 1'b0);
        send(5, 16'hBB00, 2'b10, 1'b1);
        wait_beats(1);
        expect_beat("t4", 32'h0, 128'h0000_0000_BBAA_0000_0000_0000_0000_0000, 16'h0C00, 1'b1);
        tick(3);

        // 5: async reset while a beat is pending on the output and another accumulating
        q.delete();
        m_beat_tready = 1'b0;
        send(0, 16'hAAAA, 2'b11, 1'b0);
        send(1, 16'hBBBB, 2'b11, 1'b0);
        send(8, 16'hCCCC, 2'b11, 1'b0);
        chk("t5_pre_valid", m_beat_tvalid, 1);
        resetn = 1'b0;
        #1;
        chk("t5_rst_valid", m_beat_tvalid, 0);
        chk("t5_rst_tready", s_pixel_tready, 0);
        tick(2);
        resetn = 1'b1;
        m_beat_tready = 1'b1;
        tick(10);
        chk("t5_no_stale", q.size(), 0);
        send(4, 16'h4444, 2'b11, 1'b1);
        wait_beats(1);
        tick(3);
        chk("t5_one_beat", q.size(), 1);
        expect_beat("t5", 32'h0, 128'h0000_0000_0000_4444_0000_0000_0000_0000, 16'h0300, 1'b1);

        // 6: zero-mask flush in EMPTY; beat appears two cycles after acceptance
        q.delete();
        send(2, 16'hFFFF, 2'b00, 1'b1);
        chk("t6_n1_valid", m_beat_tvalid, 0);
        chk("t6_flush_tready", s_pixel_tready, 0);
        tick();
        chk("t6_n2_valid", m_beat_tvalid, 1);
        chk("t6_n2_strb", m_beat_tstrb, 0);
        chk("t6_n2_last", m_beat_tlast, 1);
        tick(3);
        expect_beat("t6", 32'h0, 128'h0, 16'h0000, 1'b1);
        chk("t6_one_beat", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
